// File: rtl/mcoi_diag_scheduler_pkg.sv
// Shared types and constants for the board-diagnostics I2C scheduler.
// Holds the FSM state encoding, default device addresses, register pointers
// and read lengths, plus small helpers used by the scheduler datapath.
package mcoi_diag_scheduler_pkg;

   typedef enum logic [2:0] {
      S_ID_REQ    = 3'd0,
      S_ID_WAIT   = 3'd1,
      S_IDLE      = 3'd2,
      S_TEMP_REQ  = 3'd3,
      S_TEMP_WAIT = 3'd4,
      S_PWR_REQ   = 3'd5,
      S_PWR_WAIT  = 3'd6
   } diag_state_t;

   localparam logic [6:0] DEF_TEMP_ADDR  = 7'h48;
   localparam logic [6:0] DEF_POWER_ADDR = 7'h40;
   localparam logic [6:0] DEF_ID_ADDR    = 7'h50;

   localparam logic [7:0] REG_ID   = 8'h00;
   localparam logic [7:0] REG_TEMP = 8'h00;
   localparam logic [7:0] REG_PWR  = 8'h02;

   localparam logic [3:0] LEN_ID   = 4'd8;
   localparam logic [3:0] LEN_TEMP = 4'd2;
   localparam logic [3:0] LEN_PWR  = 4'd2;

   // Saturating increment for the 8-bit error counter.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'hFF) begin
         r = v;
      end else begin
         r = v + 8'd1;
      end
      return r;
   endfunction

   // True for the states in which a transaction is in flight on the bus.
   function automatic logic is_wait(input diag_state_t s);
      logic r;
      case (s)
         S_ID_WAIT, S_TEMP_WAIT, S_PWR_WAIT: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mcoi_diag_tick.sv
// Poll-period generator: a free-running 0..POLL_PERIOD-1 counter whose wrap
// sets a pending flag. Further wraps while pending collapse into the same
// request; the scheduler clears the flag when it starts a poll round. A wrap
// coinciding with a clear wins, so that period is not lost.
module mcoi_diag_tick
   import mcoi_diag_scheduler_pkg::*;
#(
   parameter int unsigned POLL_PERIOD = 10000000
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear_i,
   output logic pending_o
);

   localparam int unsigned CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(POLL_PERIOD - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          pending_q, pending_d;
   logic          wrap_s;

   // Next-state for the period counter and the collapsing pending flag.
   always_comb begin
      wrap_s    = (cnt_q == LAST);
      cnt_d     = cnt_q;
      pending_d = pending_q;
      if (wrap_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
      end
      if (wrap_s) begin
         pending_d = 1'b1;
      end else if (clear_i) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_q;
      end
   end

   // Counter and pending flag registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: rtl/mcoi_diag_scheduler.sv
// Diagnostics I2C scheduler: reads the unique-ID EEPROM once after reset
// (with bounded retries), then polls temperature and power on every period
// tick through a byte-level I2C master command/response handshake.
// All outputs are registered.
// Optional build macro: MCOI_DIAG_TIMEOUT_EN adds a per-transaction watchdog
// that turns a stuck transaction into a NACK after TIMEOUT_CYCLES cycles.
module mcoi_diag_scheduler
   import mcoi_diag_scheduler_pkg::*;
#(
   parameter int unsigned POLL_PERIOD    = 10000000,
   parameter logic [6:0]  TEMP_ADDR      = DEF_TEMP_ADDR,
   parameter logic [6:0]  POWER_ADDR     = DEF_POWER_ADDR,
   parameter logic [6:0]  ID_ADDR        = DEF_ID_ADDR,
   parameter int unsigned ID_RETRIES     = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        cmd_valid_o,
   input  logic        cmd_ready_i,
   output logic [6:0]  cmd_addr_o,
   output logic [7:0]  cmd_reg_o,
   output logic [3:0]  cmd_len_o,
   input  logic [7:0]  rd_data_i,
   input  logic        rd_valid_i,
   input  logic        done_i,
   input  logic        nack_i,
   output logic [15:0] temp_o,
   output logic [15:0] power_o,
   output logic [63:0] id_o,
   output logic        temp_valid_o,
   output logic        power_valid_o,
   output logic        id_valid_o,
   output logic [7:0]  err_cnt_o,
   output logic        busy_o
);

   diag_state_t state_q, state_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [6:0]  cmd_addr_q, cmd_addr_d;
   logic [7:0]  cmd_reg_q, cmd_reg_d;
   logic [3:0]  cmd_len_q, cmd_len_d;
   logic [63:0] shadow_q, shadow_d;
   logic [3:0]  bcnt_q, bcnt_d;
   logic [3:0]  retry_q, retry_d;
   logic [7:0]  err_q, err_d;
   logic [15:0] temp_q, temp_d;
   logic [15:0] power_q, power_d;
   logic [63:0] id_q, id_d;
   logic        temp_vld_q, temp_vld_d;
   logic        power_vld_q, power_vld_d;
   logic        id_vld_q, id_vld_d;
   logic        busy_q, busy_d;

   logic        hs_s;
   logic        ok_s;
   logic        fail_s;
   logic        timeout_s;
   logic        pending_s;
   logic        pend_clr_s;

   mcoi_diag_tick #(
      .POLL_PERIOD (POLL_PERIOD)
   ) u_tick (
      .clk       (clk),
      .rstn      (rstn),
      .clear_i   (pend_clr_s),
      .pending_o (pending_s)
   );

`ifdef MCOI_DIAG_TIMEOUT_EN
   logic [31:0] wd_q, wd_d;

   // Watchdog: counts cycles spent waiting; restarts whenever a wait ends.
   always_comb begin
      timeout_s = is_wait(state_q) && (wd_q == 32'(TIMEOUT_CYCLES - 1));
      if (is_wait(state_q) && !timeout_s && !done_i) begin
         wd_d = wd_q + 32'd1;
      end else begin
         wd_d = 32'd0;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wd_q <= 32'd0;
      end else begin
         wd_q <= wd_d;
      end
   end
`else
   logic [31:0] timeout_unused_s;
   assign timeout_unused_s = 32'(TIMEOUT_CYCLES);
   assign timeout_s        = 1'b0;
`endif

   // A real done_i takes precedence over a coincident watchdog expiry.
   assign hs_s   = cmd_valid_q & cmd_ready_i;
   assign ok_s   = done_i & ~nack_i;
   assign fail_s = done_i ? nack_i : timeout_s;

   // Next-state, shadow capture, result commit and command decode.
   always_comb begin
      state_d     = state_q;
      retry_d     = retry_q;
      err_d       = err_q;
      temp_d      = temp_q;
      power_d     = power_q;
      id_d        = id_q;
      temp_vld_d  = temp_vld_q;
      power_vld_d = power_vld_q;
      id_vld_d    = id_vld_q;
      pend_clr_s  = 1'b0;
      cmd_valid_d = 1'b0;
      cmd_addr_d  = cmd_addr_q;
      cmd_reg_d   = cmd_reg_q;
      cmd_len_d   = cmd_len_q;

      // Bytes shift in MSB first; anything past the requested length is
      // dropped. A byte strobed together with done_i is part of the commit.
      if (is_wait(state_q) && rd_valid_i && (bcnt_q < cmd_len_q)) begin
         shadow_d = {shadow_q[55:0], rd_data_i};
         bcnt_d   = bcnt_q + 4'd1;
      end else begin
         shadow_d = shadow_q;
         bcnt_d   = bcnt_q;
      end

      case (state_q)
         S_ID_REQ: begin
            if (hs_s) begin
               state_d  = S_ID_WAIT;
               shadow_d = 64'd0;
               bcnt_d   = 4'd0;
            end else begin
               state_d = S_ID_REQ;
            end
         end
         S_ID_WAIT: begin
            if (ok_s) begin
               id_d     = shadow_d;
               id_vld_d = 1'b1;
               state_d  = S_IDLE;
            end else if (fail_s) begin
               err_d = sat_inc8(err_q);
               if (retry_q < 4'(ID_RETRIES)) begin
                  retry_d = retry_q + 4'd1;
                  state_d = S_ID_REQ;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_ID_WAIT;
            end
         end
         S_IDLE: begin
            if (pending_s) begin
               pend_clr_s = 1'b1;
               state_d    = S_TEMP_REQ;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_TEMP_REQ: begin
            if (hs_s) begin
               state_d  = S_TEMP_WAIT;
               shadow_d = 64'd0;
               bcnt_d   = 4'd0;
            end else begin
               state_d = S_TEMP_REQ;
            end
         end
         S_TEMP_WAIT: begin
            if (ok_s) begin
               temp_d     = shadow_d[15:0];
               temp_vld_d = 1'b1;
               state_d    = S_PWR_REQ;
            end else if (fail_s) begin
               err_d   = sat_inc8(err_q);
               state_d = S_PWR_REQ;
            end else begin
               state_d = S_TEMP_WAIT;
            end
         end
         S_PWR_REQ: begin
            if (hs_s) begin
               state_d  = S_PWR_WAIT;
               shadow_d = 64'd0;
               bcnt_d   = 4'd0;
            end else begin
               state_d = S_PWR_REQ;
            end
         end
         S_PWR_WAIT: begin
            if (ok_s) begin
               power_d     = shadow_d[15:0];
               power_vld_d = 1'b1;
               state_d     = S_IDLE;
            end else if (fail_s) begin
               err_d   = sat_inc8(err_q);
               state_d = S_IDLE;
            end else begin
               state_d = S_PWR_WAIT;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Command fields are registered from the state being entered, so they
      // hold steady for as long as the request waits for cmd_ready_i.
      case (state_d)
         S_ID_REQ: begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = ID_ADDR;
            cmd_reg_d   = REG_ID;
            cmd_len_d   = LEN_ID;
         end
         S_TEMP_REQ: begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = TEMP_ADDR;
            cmd_reg_d   = REG_TEMP;
            cmd_len_d   = LEN_TEMP;
         end
         S_PWR_REQ: begin
            cmd_valid_d = 1'b1;
            cmd_addr_d  = POWER_ADDR;
            cmd_reg_d   = REG_PWR;
            cmd_len_d   = LEN_PWR;
         end
         default: begin
            cmd_valid_d = 1'b0;
         end
      endcase

      busy_d = is_wait(state_d);
   end

   // State, command, shadow and result registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_ID_REQ;
         cmd_valid_q <= 1'b0;
         cmd_addr_q  <= 7'd0;
         cmd_reg_q   <= 8'd0;
         cmd_len_q   <= 4'd0;
         shadow_q    <= 64'd0;
         bcnt_q      <= 4'd0;
         retry_q     <= 4'd0;
         err_q       <= 8'd0;
         temp_q      <= 16'd0;
         power_q     <= 16'd0;
         id_q        <= 64'd0;
         temp_vld_q  <= 1'b0;
         power_vld_q <= 1'b0;
         id_vld_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_reg_q   <= cmd_reg_d;
         cmd_len_q   <= cmd_len_d;
         shadow_q    <= shadow_d;
         bcnt_q      <= bcnt_d;
         retry_q     <= retry_d;
         err_q       <= err_d;
         temp_q      <= temp_d;
         power_q     <= power_d;
         id_q        <= id_d;
         temp_vld_q  <= temp_vld_d;
         power_vld_q <= power_vld_d;
         id_vld_q    <= id_vld_d;
         busy_q      <= busy_d;
      end
   end

   assign cmd_valid_o   = cmd_valid_q;
   assign cmd_addr_o    = cmd_addr_q;
   assign cmd_reg_o     = cmd_reg_q;
   assign cmd_len_o     = cmd_len_q;
   assign temp_o        = temp_q;
   assign power_o       = power_q;
   assign id_o          = id_q;
   assign temp_valid_o  = temp_vld_q;
   assign power_valid_o = power_vld_q;
   assign id_valid_o    = id_vld_q;
   assign err_cnt_o     = err_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_mcoi_diag_scheduler.sv
// Self-checking bench for mcoi_diag_scheduler (default build, short poll
// period). A behavioural I2C-master responder drives read bytes and done;
// expected commands and committed results are queued when stimulus is
// driven and popped when the DUT responds.
module tb_mcoi_diag_scheduler;

   localparam int P = 24;
   localparam int K_ID = 0;
   localparam int K_TEMP = 1;
   localparam int K_PWR = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        cmd_valid_o;
   logic        cmd_ready_i;
   logic [6:0]  cmd_addr_o;
   logic [7:0]  cmd_reg_o;
   logic [3:0]  cmd_len_o;
   logic [7:0]  rd_data_i;
   logic        rd_valid_i;
   logic        done_i;
   logic        nack_i;
   logic [15:0] temp_o;
   logic [15:0] power_o;
   logic [63:0] id_o;
   logic        temp_valid_o;
   logic        power_valid_o;
   logic        id_valid_o;
   logic [7:0]  err_cnt_o;
   logic        busy_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct packed {
      logic [6:0] a;
      logic [7:0] r;
      logic [3:0] l;
   } cmd_t;

   typedef struct packed {
      logic [63:0] w;
      logic        v;
      logic [7:0]  e;
   } exp_t;

   cmd_t cmd_q[$];
   exp_t sb_q[$];

   logic [15:0] m_temp;
   logic [15:0] m_pwr;
   logic [63:0] m_id;
   logic        m_tv;
   logic        m_pv;
   logic        m_iv;
   logic [7:0]  m_err;

   mcoi_diag_scheduler #(
      .POLL_PERIOD (P)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .cmd_valid_o   (cmd_valid_o),
      .cmd_ready_i   (cmd_ready_i),
      .cmd_addr_o    (cmd_addr_o),
      .cmd_reg_o     (cmd_reg_o),
      .cmd_len_o     (cmd_len_o),
      .rd_data_i     (rd_data_i),
      .rd_valid_i    (rd_valid_i),
      .done_i        (done_i),
      .nack_i        (nack_i),
      .temp_o        (temp_o),
      .power_o       (power_o),
      .id_o          (id_o),
      .temp_valid_o  (temp_valid_o),
      .power_valid_o (power_valid_o),
      .id_valid_o    (id_valid_o),
      .err_cnt_o     (err_cnt_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   // Cycles since reset release; the poll tick lands where cyc % P == 0.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] out_word(input int kind);
      if (kind == K_ID)        return id_o;
      else if (kind == K_TEMP) return {48'd0, temp_o};
      else                     return {48'd0, power_o};
   endfunction

   function automatic logic out_vld(input int kind);
      if (kind == K_ID)        return id_valid_o;
      else if (kind == K_TEMP) return temp_valid_o;
      else                     return power_valid_o;
   endfunction

   function automatic logic [63:0] model_word(input int kind);
      if (kind == K_ID)        return m_id;
      else if (kind == K_TEMP) return {48'd0, m_temp};
      else                     return {48'd0, m_pwr};
   endfunction

   function automatic logic model_vld(input int kind);
      if (kind == K_ID)        return m_iv;
      else if (kind == K_TEMP) return m_tv;
      else                     return m_pv;
   endfunction

   task automatic reset_dut();
      rstn = 1'b0;
      cmd_ready_i = 1'b0;
      rd_valid_i = 1'b0;
      rd_data_i = 8'd0;
      done_i = 1'b0;
      nack_i = 1'b0;
      m_temp = 16'd0; m_pwr = 16'd0; m_id = 64'd0;
      m_tv = 1'b0; m_pv = 1'b0; m_iv = 1'b0; m_err = 8'd0;
      cmd_q.delete();
      sb_q.delete();
      repeat (3) @(negedge clk);
      check("rst_cmd_valid", {63'd0, cmd_valid_o}, 64'd0);
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_id_valid", {63'd0, id_valid_o}, 64'd0);
      check("rst_temp_valid", {63'd0, temp_valid_o}, 64'd0);
      check("rst_power_valid", {63'd0, power_valid_o}, 64'd0);
      check("rst_err", {56'd0, err_cnt_o}, 64'd0);
      check("rst_words", id_o | {48'd0, temp_o} | {48'd0, power_o}, 64'd0);
      rstn = 1'b1;
   endtask

   // Waits for a command, checks it against the queued expectation, holds
   // cmd_ready_i low for stall cycles (optionally until three ticks have
   // passed and the period has just restarted), then accepts it.
   task automatic issue(input logic [6:0] a, input logic [7:0] r, input logic [3:0] l,
                        input int stall, input bit align, output int waited);
      cmd_t e;
      int   k;
      int   tk;
      cmd_q.push_back({a, r, l});
      waited = 0;
      while (!cmd_valid_o && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      e = cmd_q.pop_front();
      check("cmd_seen", {63'd0, cmd_valid_o}, 64'd1);
      if (cmd_valid_o) begin
         check("cmd_addr", {57'd0, cmd_addr_o}, {57'd0, e.a});
         check("cmd_reg", {56'd0, cmd_reg_o}, {56'd0, e.r});
         check("cmd_len", {60'd0, cmd_len_o}, {60'd0, e.l});
         k = 0;
         tk = 0;
         while ((k < stall || (align && (tk < 3 || (cyc % P) != 1))) && k < 300) begin
            @(negedge clk);
            k++;
            if ((cyc % P) == 0) tk++;
            check("stall_valid", {63'd0, cmd_valid_o}, 64'd1);
            check("stall_fields", {45'd0, cmd_addr_o, cmd_reg_o, cmd_len_o}, {45'd0, e.a, e.r, e.l});
         end
         if (align) check("stall_ticks", {63'd0, tk >= 3}, 64'd1);
         cmd_ready_i = 1'b1;
         @(negedge clk);
         cmd_ready_i = 1'b0;
         check("busy_wait", {63'd0, busy_o}, 64'd1);
         check("cmd_dropped", {63'd0, cmd_valid_o}, 64'd0);
      end
   endtask

   // Plays a read response of nbytes (MSB first) then done/nack; the last
   // byte may share the cycle with done. Checks the commit one cycle later.
   task automatic serve(input int kind, input logic [63:0] data, input int nbytes,
                        input bit nack, input bit with_last);
      logic [63:0] sh;
      logic [63:0] old;
      logic [7:0]  b;
      int          len;
      exp_t        e;
      len = (kind == K_ID) ? 8 : 2;
      sh = 64'd0;
      for (int i = 0; i < nbytes; i++) begin
         b = data[8*(nbytes-1-i) +: 8];
         if (i < len) sh = {sh[55:0], b};
      end
      old = model_word(kind);
      if (!nack) begin
         if (kind == K_ID) begin m_id = sh; m_iv = 1'b1; end
         else if (kind == K_TEMP) begin m_temp = sh[15:0]; m_tv = 1'b1; end
         else begin m_pwr = sh[15:0]; m_pv = 1'b1; end
      end else begin
         m_err = (m_err == 8'hFF) ? 8'hFF : m_err + 8'd1;
      end
      e.w = model_word(kind);
      e.v = model_vld(kind);
      e.e = m_err;
      sb_q.push_back(e);
      for (int i = 0; i < nbytes; i++) begin
         rd_valid_i = 1'b1;
         rd_data_i = data[8*(nbytes-1-i) +: 8];
         if (with_last && i == nbytes - 1) begin
            done_i = 1'b1;
            nack_i = nack;
            check("precommit", out_word(kind), old);
         end
         @(negedge clk);
      end
      rd_valid_i = 1'b0;
      rd_data_i = 8'd0;
      if (!(with_last && nbytes > 0)) begin
         done_i = 1'b1;
         nack_i = nack;
         check("precommit", out_word(kind), old);
         @(negedge clk);
      end
      done_i = 1'b0;
      nack_i = 1'b0;
      e = sb_q.pop_front();
      check("word", out_word(kind), e.w);
      check("valid", {63'd0, out_vld(kind)}, {63'd0, e.v});
      check("err_cnt", {56'd0, err_cnt_o}, {56'd0, e.e});
      check("busy_done", {63'd0, busy_o}, 64'd0);
   endtask

   initial begin
      int w;
      int k;
      rstn = 1'b0;
      @(negedge clk);
      reset_dut();

      // ID read, then idle until the first tick.
      issue(7'h50, 8'h00, 4'd8, 0, 1'b0, w);
      serve(K_ID, 64'h0102030405060708, 8, 1'b0, 1'b1);
      check("idle_after_id", {63'd0, cmd_valid_o}, 64'd0);
      issue(7'h48, 8'h00, 4'd2, 0, 1'b0, w);
      check("first_tick", {63'd0, cyc >= P}, 64'd1);
      serve(K_TEMP, 64'h1A80, 2, 1'b0, 1'b0);
      issue(7'h40, 8'h02, 4'd2, 0, 1'b0, w);
      serve(K_PWR, 64'h03E8, 2, 1'b0, 1'b0);

      // TEMP NACK keeps the old word; PWR still issued; extra bytes dropped.
      issue(7'h48, 8'h00, 4'd2, 0, 1'b0, w);
      serve(K_TEMP, 64'h55, 1, 1'b1, 1'b0);
      issue(7'h40, 8'h02, 4'd2, 0, 1'b0, w);
      serve(K_PWR, 64'h123456, 3, 1'b0, 1'b1);

      // Backpressure across several ticks: exactly one extra round follows.
      issue(7'h48, 8'h00, 4'd2, 50, 1'b1, w);
      serve(K_TEMP, 64'h2B11, 2, 1'b0, 1'b0);
      issue(7'h40, 8'h02, 4'd2, 0, 1'b0, w);
      serve(K_PWR, 64'h0064, 2, 1'b0, 1'b0);
      issue(7'h48, 8'h00, 4'd2, 0, 1'b0, w);
      check("extra_round_prompt", {63'd0, w <= 3}, 64'd1);
      serve(K_TEMP, 64'h2C22, 2, 1'b0, 1'b0);
      issue(7'h40, 8'h02, 4'd2, 0, 1'b0, w);
      serve(K_PWR, 64'h0065, 2, 1'b0, 1'b0);
      k = 0;
      while ((cyc % P) != 0 && k < P) begin
         check("no_double_round", {63'd0, cmd_valid_o}, 64'd0);
         @(negedge clk);
         k++;
      end

      // Error counter saturation through repeated NACK rounds.
      for (int r = 0; r < 130; r++) begin
         issue(7'h48, 8'h00, 4'd2, 0, 1'b0, w);
         serve(K_TEMP, 64'h0, 0, 1'b1, 1'b0);
         issue(7'h40, 8'h02, 4'd2, 0, 1'b0, w);
         serve(K_PWR, 64'h0, 0, 1'b1, 1'b0);
      end
      check("err_saturated", {56'd0, err_cnt_o}, 64'hFF);

      // Reset in the middle of a transaction.
      issue(7'h48, 8'h00, 4'd2, 0, 1'b0, w);
      reset_dut();

      // ID NACK on all four attempts, then polling proceeds without ID.
      for (int r = 0; r < 4; r++) begin
         issue(7'h50, 8'h00, 4'd8, 0, 1'b0, w);
         serve(K_ID, 64'h0, 0, 1'b1, 1'b0);
      end
      check("id_invalid", {63'd0, id_valid_o}, 64'd0);
      check("id_err4", {56'd0, err_cnt_o}, 64'd4);
      issue(7'h48, 8'h00, 4'd2, 0, 1'b0, w);
      serve(K_TEMP, 64'h1A80, 2, 1'b0, 1'b1);
      issue(7'h40, 8'h02, 4'd2, 0, 1'b0, w);
      serve(K_PWR, 64'h03E8, 2, 1'b0, 1'b1);
      check("id_still_invalid", {63'd0, id_valid_o}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
